// File: rtl/wb_pkg.sv
// Shared types and load-extension helper for the writeback stage.
// Widths here fix the layout of a buffered writeback entry.
package wb_pkg;

  localparam int WB_DATA_W     = 32;
  localparam int WB_REG_ADDR_W = 6;

  localparam logic [2:0] LT_WORD   = 3'd0;
  localparam logic [2:0] LT_BYTE_S = 3'd1;
  localparam logic [2:0] LT_BYTE_U = 3'd2;
  localparam logic [2:0] LT_HALF_S = 3'd3;
  localparam logic [2:0] LT_HALF_U = 3'd4;

  typedef struct packed {
    logic                     regwrite;
    logic [WB_REG_ADDR_W-1:0] dest;
    logic [WB_DATA_W-1:0]     data;
  } wb_entry_t;

  // Big-endian lane select: byte k lives at word[31-8k -: 8].
  function automatic logic [WB_DATA_W-1:0] extend(
    input logic [2:0]           load_type,
    input logic [1:0]           addr_lo,
    input logic [WB_DATA_W-1:0] word
  );
    logic signed [7:0]           byte_s;
    logic signed [15:0]          half_s;
    logic signed [WB_DATA_W-1:0] byte_x;
    logic signed [WB_DATA_W-1:0] half_x;
    logic [WB_DATA_W-1:0]        result;

    unique case (addr_lo)
      2'd0:    byte_s = word[31:24];
      2'd1:    byte_s = word[23:16];
      2'd2:    byte_s = word[15:8];
      default: byte_s = word[7:0];
    endcase
    half_s = addr_lo[1] ? word[15:0] : word[31:16];
    byte_x = byte_s;
    half_x = half_s;

    unique case (load_type)
      LT_BYTE_S: result = byte_x;
      LT_BYTE_U: result = {24'd0, byte_s};
      LT_HALF_S: result = half_x;
      LT_HALF_U: result = {16'd0, half_s};
      default:   result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry FIFO buffering completed instructions ahead of the register file.
// Storage carries no reset; only pointers and occupancy are cleared.
module wb_skid_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  wb_entry_t        wr_entry,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/wb_writeback_stage.sv
// Writeback stage: buffers MEM results, extends load data, and drives the
// register file write port one cycle after an entry reaches the FIFO head.
module wb_writeback_stage
  import wb_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int REG_ADDR_W = WB_REG_ADDR_W,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_regwrite,
  input  logic                  in_memtoreg,
  input  logic [2:0]            in_load_type,
  input  logic [1:0]            in_addr_lo,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_mem_data,
  input  logic                  wb_hold,
  output logic                  regwrite,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0]     write_data,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_reg,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [31:0]           retire_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        entry_p0;
  wb_entry_t        head_p0;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  logic                  regwrite_p1;
  logic [REG_ADDR_W-1:0] write_reg_p1;
  logic [DATA_W-1:0]     write_data_p1;
  logic [31:0]           retire_cnt_p1;

  // ---- stage p0: final data is resolved before it enters the FIFO ----
  always_comb begin
    entry_p0          = '0;
    entry_p0.regwrite = in_regwrite;
    entry_p0.dest     = in_dest;
    entry_p0.data     = in_memtoreg ? extend(in_load_type, in_addr_lo, in_mem_data)
                                    : in_alu_result;
  end

  // in_ready looks only at registered occupancy and reset, never at in_valid/wb_hold.
  assign in_ready = !full && rst_n;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && !wb_hold;

  wb_skid_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .wr_entry (entry_p0),
    .head     (head_p0),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign fwd_valid = !empty && head_p0.regwrite && (head_p0.dest != '0);
  assign fwd_reg   = head_p0.dest;
  assign fwd_data  = head_p0.data;

  // ---- stage p1: registered register-file write command ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regwrite_p1   <= 1'b0;
      write_reg_p1  <= '0;
      write_data_p1 <= '0;
      retire_cnt_p1 <= '0;
    end else if (pop) begin
      regwrite_p1   <= head_p0.regwrite && (head_p0.dest != '0);
      write_reg_p1  <= head_p0.dest;
      write_data_p1 <= head_p0.data;
      retire_cnt_p1 <= retire_cnt_p1 + 32'd1;
    end else begin
      regwrite_p1   <= 1'b0;
    end
  end

  assign regwrite     = regwrite_p1;
  assign write_reg    = write_reg_p1;
  assign write_data   = write_data_p1;
  assign retire_count = retire_cnt_p1;

endmodule

// File: tb/tb_wb_writeback_stage.sv
// Directed bench for wb_writeback_stage with hand-computed expectations.
module tb_wb_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_regwrite;
  logic        in_memtoreg;
  logic [2:0]  in_load_type;
  logic [1:0]  in_addr_lo;
  logic [5:0]  in_dest;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_data;
  logic        wb_hold;
  logic        regwrite;
  logic [5:0]  write_reg;
  logic [31:0] write_data;
  logic        fwd_valid;
  logic [5:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic [31:0] retire_count;

  int checks = 0;
  int errors = 0;

  wb_writeback_stage #(.DATA_W(32), .REG_ADDR_W(6), .DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_regwrite   (in_regwrite),
    .in_memtoreg   (in_memtoreg),
    .in_load_type  (in_load_type),
    .in_addr_lo    (in_addr_lo),
    .in_dest       (in_dest),
    .in_alu_result (in_alu_result),
    .in_mem_data   (in_mem_data),
    .wb_hold       (wb_hold),
    .regwrite      (regwrite),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .fwd_valid     (fwd_valid),
    .fwd_reg       (fwd_reg),
    .fwd_data      (fwd_data),
    .retire_count  (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic mtr, input logic [2:0] lt,
                       input logic [1:0] alo, input logic [5:0] dest,
                       input logic [31:0] alu, input logic [31:0] mem);
    in_valid      = 1'b1;
    in_regwrite   = rw;
    in_memtoreg   = mtr;
    in_load_type  = lt;
    in_addr_lo    = alo;
    in_dest       = dest;
    in_alu_result = alu;
    in_mem_data   = mem;
  endtask

  // Push one load, then check the write one edge later.
  task automatic load_case(input string tag, input logic [2:0] lt, input logic [1:0] alo,
                           input logic [31:0] exp_data, input logic [31:0] exp_retire);
    drive(1'b1, 1'b1, lt, alo, 6'd5, 32'hDEADBEEF, 32'h8812F0A5);
    step();
    in_valid = 1'b0;
    check({tag, "_fwd"}, fwd_data, exp_data);
    step();
    check({tag, "_rw"}, {31'd0, regwrite}, 32'd1);
    check({tag, "_data"}, write_data, exp_data);
    check({tag, "_retire"}, retire_count, exp_retire);
  endtask

  initial begin
    rst_n = 1'b0;
    wb_hold = 1'b0;
    in_valid = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 2'd0, 6'd0, 32'd0, 32'd0);
    in_valid = 1'b0;
    step();
    step();

    check("rst_regwrite", {31'd0, regwrite}, 32'd0);
    check("rst_write_reg", {26'd0, write_reg}, 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_retire", retire_count, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Single ALU write
    drive(1'b1, 1'b0, 3'd0, 2'd0, 6'd4, 32'hFFFFFFFF, 32'h0);
    step();
    in_valid = 1'b0;
    check("alu_not_yet", {31'd0, regwrite}, 32'd0);
    check("alu_fwd_valid", {31'd0, fwd_valid}, 32'd1);
    check("alu_fwd_reg", {26'd0, fwd_reg}, 32'd4);
    step();
    check("alu_rw", {31'd0, regwrite}, 32'd1);
    check("alu_reg", {26'd0, write_reg}, 32'd4);
    check("alu_data", write_data, 32'hFFFFFFFF);
    check("alu_retire", retire_count, 32'd1);
    step();
    check("alu_pulse_end", {31'd0, regwrite}, 32'd0);
    check("alu_reg_hold", {26'd0, write_reg}, 32'd4);

    // Load extension on 8812F0A5
    load_case("byte_s0", 3'd1, 2'd0, 32'hFFFFFF88, 32'd2);
    load_case("byte_u3", 3'd2, 2'd3, 32'h000000A5, 32'd3);
    load_case("half_s2", 3'd3, 2'd2, 32'hFFFFF0A5, 32'd4);
    load_case("half_u0", 3'd4, 2'd0, 32'h00008812, 32'd5);
    load_case("byte_s1", 3'd1, 2'd1, 32'h00000012, 32'd6);
    load_case("half_s3", 3'd3, 2'd3, 32'hFFFFF0A5, 32'd7);
    load_case("word", 3'd0, 2'd2, 32'h8812F0A5, 32'd8);
    load_case("code6", 3'd6, 2'd1, 32'h8812F0A5, 32'd9);

    // Hold with three back-to-back push attempts
    wb_hold = 1'b1;
    drive(1'b1, 1'b0, 3'd0, 2'd0, 6'd10, 32'h0000000A, 32'h0);
    step();
    drive(1'b1, 1'b0, 3'd0, 2'd0, 6'd11, 32'h0000000B, 32'h0);
    step();
    check("full_ready", {31'd0, in_ready}, 32'd0);
    check("hold_rw0", {31'd0, regwrite}, 32'd0);
    drive(1'b1, 1'b0, 3'd0, 2'd0, 6'd12, 32'h0000000C, 32'h0);
    step();
    check("full_ready2", {31'd0, in_ready}, 32'd0);
    check("hold_rw1", {31'd0, regwrite}, 32'd0);
    check("hold_head", {26'd0, fwd_reg}, 32'd10);
    wb_hold = 1'b0;
    step();
    check("rel_rw_a", {31'd0, regwrite}, 32'd1);
    check("rel_reg_a", {26'd0, write_reg}, 32'd10);
    check("rel_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("rel_rw_b", {31'd0, regwrite}, 32'd1);
    check("rel_reg_b", {26'd0, write_reg}, 32'd11);
    step();
    check("rel_rw_c", {31'd0, regwrite}, 32'd1);
    check("rel_reg_c", {26'd0, write_reg}, 32'd12);
    check("rel_data_c", write_data, 32'h0000000C);
    step();
    check("rel_idle", {31'd0, regwrite}, 32'd0);
    check("rel_retire", retire_count, 32'd12);

    // Register 0 and a non-writing entry
    drive(1'b1, 1'b0, 3'd0, 2'd0, 6'd0, 32'h12345678, 32'h0);
    step();
    in_valid = 1'b0;
    check("r0_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    step();
    check("r0_rw", {31'd0, regwrite}, 32'd0);
    check("r0_retire", retire_count, 32'd13);
    drive(1'b0, 1'b0, 3'd0, 2'd0, 6'd7, 32'h55AA55AA, 32'h0);
    step();
    in_valid = 1'b0;
    check("nowr_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    step();
    check("nowr_rw", {31'd0, regwrite}, 32'd0);
    check("nowr_retire", retire_count, 32'd14);

    // Reset with two entries buffered
    wb_hold = 1'b1;
    drive(1'b1, 1'b0, 3'd0, 2'd0, 6'd20, 32'h00000014, 32'h0);
    step();
    drive(1'b1, 1'b0, 3'd0, 2'd0, 6'd21, 32'h00000015, 32'h0);
    step();
    in_valid = 1'b0;
    check("mid_full", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    wb_hold = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("mid_rst_rw", {31'd0, regwrite}, 32'd0);
    check("mid_rst_retire", retire_count, 32'd0);
    check("mid_rst_fwd", {31'd0, fwd_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("mid_no_write", {31'd0, regwrite}, 32'd0);
    check("mid_empty_fwd", {31'd0, fwd_valid}, 32'd0);

    // Streaming: eight consecutive pushes
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, 3'd0, 2'd0, 6'(i), 32'(i * 3), 32'h0);
      step();
      check("stream_ready", {31'd0, in_ready}, 32'd1);
      if (i > 1) begin
        check("stream_rw", {31'd0, regwrite}, 32'd1);
        check("stream_reg", {26'd0, write_reg}, 32'(i - 1));
        check("stream_data", write_data, 32'((i - 1) * 3));
      end
    end
    in_valid = 1'b0;
    step();
    check("stream_last_reg", {26'd0, write_reg}, 32'd8);
    check("stream_last_data", write_data, 32'd24);
    check("stream_retire", retire_count, 32'd8);
    step();
    check("stream_idle", {31'd0, regwrite}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_writeback_stage.md
Name: wb_writeback_stage

Overview:
- Writeback stage sitting directly upstream of the registerfile write port (regwrite / write_reg / write_data).
- Accepts completed instructions from the MEM stage over a valid/ready handshake and buffers them in a 2-entry skid FIFO.
- Performs load-data extraction and extension, and selects ALU vs memory result.
- Drives registered write commands into the register file, suppressing writes to register 0.

Parameters:
- DATA_W, 32, datapath width.
- REG_ADDR_W, 6, register address width; matches registerfile read_reg/write_reg.
- DEPTH, 2, skid FIFO entries; only 2 is supported.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept; equals (count<DEPTH) && rst_n.
- in_regwrite  in  1  instruction writes a register.
- in_memtoreg  in  1  1 = result from in_mem_data, 0 = in_alu_result.
- in_load_type  in  3  load extension code (see wb_pkg).
- in_addr_lo  in  2  low address bits of the load.
- in_dest  in  REG_ADDR_W  destination register.
- in_alu_result  in  DATA_W  ALU result.
- in_mem_data  in  DATA_W  raw memory word.
- wb_hold  in  1  hazard unit blocks writeback this cycle.
- regwrite  out  1  registerfile write enable (registered).
- write_reg  out  REG_ADDR_W  registerfile write address (registered).
- write_data  out  DATA_W  registerfile write data (registered).
- fwd_valid  out  1  FIFO head is a pending write to a non-zero register.
- fwd_reg  out  REG_ADDR_W  head destination, for forwarding.
- fwd_data  out  DATA_W  head final data, for forwarding.
- retire_count  out  32  number of entries popped; wraps modulo 2^32.

Behaviour:
- Reset (rst_n=0 at posedge):
  - count=0; regwrite=0, write_reg=0, write_data=0, retire_count=0.
  - in_ready=0 while rst_n is low.
  - Reset mid-operation discards all buffered entries; no write issues on the following cycle.
- Push occurs on (in_valid && in_ready). The final data is computed at push time and stored as {regwrite, dest, data}.
- Data select:
  - in_memtoreg=0 -> in_alu_result.
  - in_memtoreg=1 -> extended in_mem_data. Byte order is big-endian: byte k at bits [31-8k -: 8].
- Load types:
  - LT_WORD=0: word.
  - LT_BYTE_S=1: byte, sign-extended; byte selected by addr_lo.
  - LT_BYTE_U=2: byte, zero-extended.
  - LT_HALF_S=3: half, sign-extended; addr_lo[1]=0 -> [31:16], 1 -> [15:0]. addr_lo[0] is ignored.
  - LT_HALF_U=4: half, zero-extended.
  - Codes 5-7 behave as word.
- Pop occurs when count>0 && !wb_hold. On pop, at the same edge:
  - regwrite <= head.regwrite && head.dest!=0.
  - write_reg <= head.dest; write_data <= head.data.
  - retire_count increments.
- No pop (empty or wb_hold=1): regwrite <= 0; write_reg and write_data hold their values.
- Latency: an entry pushed at edge E into an empty FIFO with no hold appears on regwrite/write_reg/write_data after edge E+1. The registerfile captures it at E+2.
- Simultaneous push and pop: allowed whenever in_ready=1; count is unchanged and order is preserved (FIFO).
- Full (count=2): in_ready=0. in_ready depends only on registered count, with no combinational path from in_valid or wb_hold.
- Dest 0 with regwrite=1: popped and counted, but regwrite output stays 0.
- Dest 0: fwd_valid=0.
- Entries with in_regwrite=0: popped and counted, never written.
- fwd_*: combinational from the FIFO head.
  - fwd_valid = count>0 && head.regwrite && head.dest!=0.
  - fwd_reg and fwd_data are the head's dest and data; they are don't-care when fwd_valid=0.
- In-flight entries are never dropped; sustained throughput is 1 entry/cycle when wb_hold=0.

Decomposition:
- wb_pkg holds:
  - the LT_* load-type constants;
  - the wb_entry_t typedef {regwrite, dest[REG_ADDR_W], data[DATA_W]};
  - the extend function: load_type, addr_lo, word -> data.
- Sub-module wb_skid_fifo: a 2-entry FIFO with push/pop/count, head and full outputs, and synchronous active-low reset.
- The top level contains the extend logic, the output registers, and the counter.

Test Plan:
- Reset then a single ALU write: in_dest=4, in_alu_result=32'hFFFFFFFF, memtoreg=0 at edge E -> regwrite=1, write_reg=4, write_data=32'hFFFFFFFF after E+1; retire_count=1.
- Loads with in_mem_data=32'h8812F0A5:
  - LT_BYTE_S, addr_lo=0 -> 32'hFFFFFF88.
  - LT_BYTE_U, addr_lo=3 -> 32'h000000A5.
  - LT_HALF_S, addr_lo=2 -> 32'hFFFFF0A5.
  - LT_HALF_U, addr_lo=0 -> 32'h00008812.
- Hold/full: wb_hold=1 while 3 back-to-back pushes are attempted.
  - in_ready drops after 2 accepts; regwrite stays 0.
  - After release, writes occur in order on consecutive cycles; the third is accepted once in_ready returns to 1.
- Write to register 0: in_dest=0, regwrite=1, data=32'h12345678 -> regwrite output 0, fwd_valid=0, retire_count still increments.
- Reset mid-operation: FIFO holds 2 entries, rst_n=0 for one edge -> regwrite=0, count=0, retire_count=0, in_ready=0 during reset and 1 the cycle after.
- Streaming: 8 pushes on consecutive cycles, wb_hold=0 -> 8 consecutive regwrite pulses (dest 1..8, data = dest*3), in_ready never drops, retire_count=8.
